// File: rtl/black_in_feeder.sv
// Byte-to-word packer with a small word FIFO and a fixed-rate presenter that
// paces 32-bit words onto a handshake-less downstream wrapper input.
module black_in_feeder #(
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [31:0] IDLE_WORD   = 32'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [7:0]               io_in_byte,
    input  logic                     io_in_last,
    output logic [31:0]              io_out_a,
    output logic                     io_out_strobe,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_busy
);

    // state  | meaning
    // S_IDLE | nothing being held; io_out_a keeps its last value
    // S_HOLD | a word is on io_out_a, hold counter running down to 0
    typedef enum logic {S_IDLE, S_HOLD} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     part_q, part_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic [31:0]     out_q;
    logic            strobe_q;
    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic [31:0]     word;

    assign io_in_ready = (count_q < FULL_COUNT);
    assign accept      = io_in_valid && io_in_ready;
    assign word        = part_q | ({24'h0, io_in_byte} << {idx_q, 3'b000});
    // A last byte closes the word; upper bytes stay zero because part_q was cleared.
    assign push        = accept && ((idx_q == 2'd3) || io_in_last);

    always_comb begin
        idx_d  = idx_q;
        part_d = part_q;
        if (push) begin
            idx_d  = 2'd0;
            part_d = 32'h0;
        end else if (accept) begin
            idx_d  = idx_q + 2'd1;
            part_d = word;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = HOLD_RELOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (count_q != '0) begin
                    pop    = 1'b1;
                    hold_d = HOLD_RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            idx_q    <= 2'd0;
            part_q   <= 32'h0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            out_q    <= IDLE_WORD;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            part_q   <= part_d;
            count_q  <= count_d;
            strobe_q <= pop;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                out_q  <= mem_q[rptr_q];
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= word;
    end

    assign io_out_a      = out_q;
    assign io_out_strobe = strobe_q;
    assign io_count      = count_q;
    assign io_busy       = (idx_q != 2'd0) || (count_q != '0) || (state_q == S_HOLD);

endmodule

// File: tb/tb_black_in_feeder.sv
// Scoreboard bench: three feeders (hold 4, 8, 1) driven by random byte streams;
// a byte-level reference model queues expected words, a negedge monitor checks them.
module tb_black_in_feeder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        vld  [3];
    logic        lst  [3];
    logic [7:0]  byt  [3];
    logic        rdy  [3];
    logic        stb  [3];
    logic        bsy  [3];
    logic [31:0] outa [3];
    logic [2:0]  cnt  [3];

    int errors = 0;
    int checks = 0;

    black_in_feeder #(.DEPTH(4), .HOLD_CYCLES(4), .IDLE_WORD(32'h0)) u0 (
        .clock(clock), .reset(reset), .io_in_valid(vld[0]), .io_in_ready(rdy[0]),
        .io_in_byte(byt[0]), .io_in_last(lst[0]), .io_out_a(outa[0]),
        .io_out_strobe(stb[0]), .io_count(cnt[0]), .io_busy(bsy[0]));
    black_in_feeder #(.DEPTH(4), .HOLD_CYCLES(8), .IDLE_WORD(32'h0)) u1 (
        .clock(clock), .reset(reset), .io_in_valid(vld[1]), .io_in_ready(rdy[1]),
        .io_in_byte(byt[1]), .io_in_last(lst[1]), .io_out_a(outa[1]),
        .io_out_strobe(stb[1]), .io_count(cnt[1]), .io_busy(bsy[1]));
    black_in_feeder #(.DEPTH(4), .HOLD_CYCLES(1), .IDLE_WORD(32'h0)) u2 (
        .clock(clock), .reset(reset), .io_in_valid(vld[2]), .io_in_ready(rdy[2]),
        .io_in_byte(byt[2]), .io_in_last(lst[2]), .io_out_a(outa[2]),
        .io_out_strobe(stb[2]), .io_count(cnt[2]), .io_busy(bsy[2]));

    function automatic int hc(int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 1);
    endfunction

    // expected-word queues, one per feeder
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    function automatic void push_exp(int k, logic [31:0] w);
        case (k)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [31:0] pop_exp(int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: byte position and accumulated word per feeder
    int          midx  [3];
    logic [31:0] mword [3];

    // monitor bookkeeping
    int          since   [3];
    logic        seen    [3];
    logic        exact   [3];
    logic        sawfull [3];
    logic [31:0] lastout [3];

    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                chk("ready_vs_count", {31'h0, rdy[k]}, {31'h0, (cnt[k] < 3'd4)});
                chk("count_max", {31'h0, (cnt[k] <= 3'd4)}, 32'h1);
                if (cnt[k] == 3'd4) sawfull[k] = 1'b1;
                if (stb[k]) begin
                    if (qsize(k) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word inst=%0d actual=%h expected=none", k, outa[k]);
                    end else begin
                        chk("word", outa[k], pop_exp(k));
                    end
                    if (seen[k]) begin
                        if (exact[k]) chk("strobe_spacing", since[k], hc(k));
                        else          chk("hold_min", {31'h0, (since[k] >= hc(k))}, 32'h1);
                    end
                    seen[k]  = 1'b1;
                    since[k] = 1;
                end else begin
                    chk("hold_stable", outa[k], lastout[k]);
                    since[k]++;
                end
                lastout[k] = outa[k];
            end
        end
    end

    task automatic clear_model();
        q0.delete(); q1.delete(); q2.delete();
        for (int k = 0; k < 3; k++) begin
            midx[k] = 0; mword[k] = 32'h0; since[k] = 0; seen[k] = 1'b0;
            exact[k] = 1'b0; sawfull[k] = 1'b0; lastout[k] = 32'h0;
            vld[k] = 1'b0; lst[k] = 1'b0; byt[k] = 8'h0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, input logic l);
        logic r;
        int   guard;
        guard  = 0;
        vld[k] = 1'b1;
        byt[k] = b;
        lst[k] = l;
        forever begin
            r = rdy[k];
            @(posedge clock);
            #1;
            if (r) break;
            guard++;
            if (guard >= 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout inst=%0d actual=stalled expected=accepted", k);
                vld[k] = 1'b0;
                return;
            end
        end
        vld[k] = 1'b0;
        lst[k] = 1'b0;
        mword[k] = mword[k] + ({24'h0, b} << (8 * midx[k]));
        midx[k]++;
        if (midx[k] == 4 || l) begin
            push_exp(k, mword[k]);
            mword[k] = 32'h0;
            midx[k]  = 0;
        end
    endtask

    task automatic drain(input int k);
        int guard;
        guard = 0;
        while ((qsize(k) != 0 || bsy[k]) && guard < 2000) begin
            cyc(1);
            guard++;
        end
        chk("drain_done", {31'h0, (guard < 2000)}, 32'h1);
        chk("drain_busy", {31'h0, bsy[k]}, 32'h0);
        chk("drain_count", {29'h0, cnt[k]}, 32'h0);
    endtask

    task automatic check_reset_state(input int k);
        chk("rst_out", outa[k], 32'h0);
        chk("rst_strobe", {31'h0, stb[k]}, 32'h0);
        chk("rst_count", {29'h0, cnt[k]}, 32'h0);
        chk("rst_busy", {31'h0, bsy[k]}, 32'h0);
        chk("rst_ready", {31'h0, rdy[k]}, 32'h1);
    endtask

    logic [31:0] w3;

    initial begin
        clear_model();
        reset = 1'b1;
        cyc(2);
        for (int k = 0; k < 3; k++) check_reset_state(k);
        reset = 1'b0;
        cyc(1);

        // single full word, exact latency and hold length
        send_byte(0, 8'h11, 1'b0);
        send_byte(0, 8'h22, 1'b0);
        send_byte(0, 8'h33, 1'b0);
        send_byte(0, 8'h44, 1'b0);
        cyc(1);
        chk("first_word", outa[0], 32'h44332211);
        chk("first_strobe", {31'h0, stb[0]}, 32'h1);
        cyc(1);
        chk("strobe_one_cycle", {31'h0, stb[0]}, 32'h0);
        cyc(3);
        chk("idle_keeps_word", outa[0], 32'h44332211);
        chk("idle_not_busy", {31'h0, bsy[0]}, 32'h0);

        // early close with last, then a clean full word
        send_byte(0, 8'hAA, 1'b0);
        send_byte(0, 8'hBB, 1'b1);
        drain(0);
        chk("last_padded", outa[0], 32'h0000BBAA);
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h02, 1'b0);
        send_byte(0, 8'h03, 1'b0);
        send_byte(0, 8'h04, 1'b0);
        drain(0);
        chk("after_last_word", outa[0], 32'h04030201);

        // backpressure: hold 8 with a continuous stream fills the FIFO
        seen[1]  = 1'b0;
        exact[1] = 1'b1;
        for (int i = 0; i < 40; i++) send_byte(1, 8'($urandom), 1'b0);
        drain(1);
        exact[1] = 1'b0;
        chk("saw_full", {31'h0, sawfull[1]}, 32'h1);

        // hold 1: single-byte words back to back give a strobe every cycle
        seen[2]  = 1'b0;
        exact[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w3 = {24'h0, 8'($urandom)};
            send_byte(2, w3[7:0], 1'b1);
        end
        drain(2);
        exact[2] = 1'b0;
        chk("hold1_keeps_last", outa[2], w3);

        // random streams with gaps and early closes, wraps the pointers
        for (int k = 0; k < 3; k += 2) begin
            for (int i = 0; i < 48; i++) begin
                send_byte(k, 8'($urandom), ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 6));
            end
            if (midx[k] != 0) send_byte(k, 8'($urandom), 1'b1);
            drain(k);
        end

        // reset mid-hold with two queued words and a half-built word
        for (int i = 0; i < 18; i++) send_byte(1, 8'($urandom), 1'b0);
        chk("pre_rst_count", {29'h0, cnt[1]}, 32'h2);
        chk("pre_rst_busy", {31'h0, bsy[1]}, 32'h1);
        reset = 1'b1;
        #1;
        check_reset_state(1);
        clear_model();
        cyc(2);
        reset = 1'b0;
        cyc(1);
        send_byte(1, 8'hDE, 1'b0);
        send_byte(1, 8'hAD, 1'b0);
        send_byte(1, 8'hBE, 1'b0);
        send_byte(1, 8'hEF, 1'b0);
        drain(1);
        chk("post_rst_word", outa[1], 32'hEFBEADDE);

        for (int k = 0; k < 3; k++) chk("queue_empty", qsize(k), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/black_in_feeder.md
Name: black_in_feeder

Overview:
- Upstream stage for the `Black` blackbox wrapper.
- Accepts a byte stream through a valid/ready handshake and packs each group of four bytes into one 32-bit word, little-endian.
- Buffers packed words in a small FIFO.
- Drives each word onto the wrapper's 32-bit input for a fixed number of cycles. The wrapper has no handshake, so this block owns all pacing.

Parameters:
- DEPTH, 4, word FIFO entries; power of 2, ≥2.
- HOLD_CYCLES, 4, cycles each word is held on io_out_a; ≥1.
- IDLE_WORD, 32'h0, io_out_a value after reset until the first word is presented.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- io_in_valid  in  1  byte available.
- io_in_ready  out  1  block can accept a byte this cycle.
- io_in_byte  in  8  data byte.
- io_in_last  in  1  qualifies with valid; closes the current word early.
- io_out_a  out  32  word driven to the downstream wrapper's io_in_a.
- io_out_strobe  out  1  high for exactly the first cycle a newly loaded word is on io_out_a.
- io_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- io_busy  out  1  any partial word, queued word, or hold in progress.

Behaviour:
- Reset (async assert, synchronous deassert edge is the user's concern):
  - byte index = 0, partial word = 0, FIFO empty, state = IDLE, hold counter = 0.
  - io_out_a = IDLE_WORD, io_out_strobe = 0, io_count = 0, io_busy = 0, io_in_ready = 1.
  - Reset mid-word or mid-hold discards all data.
- Handshake:
  - A byte transfers on an edge where io_in_valid && io_in_ready.
  - io_in_ready = (io_count < DEPTH). It is combinational from registered count only and never depends on io_in_valid.
  - While the FIFO is full, no byte is accepted, including non-completing bytes.
- Packing:
  - Accepted byte k (index 0..3) lands in bits [8k+7:8k].
  - A word is complete when index 3 is accepted, or when any byte with io_in_last=1 is accepted.
  - With io_in_last, unfilled upper bytes are zero-padded.
  - On completion the word is pushed into the FIFO on the same edge, and the index returns to 0.
  - io_in_last on byte 3 behaves the same as a normal completion.
- FIFO: circular buffer with wrapping read/write pointers.
  - A push and a pop on the same edge leave io_count unchanged.
  - A pop and a push can coincide at full: the pop occurs and ready was 0, so no push.
- Presenter FSM:
  - IDLE: io_out_a keeps its last value.
    - If FIFO non-empty: pop, load io_out_a, hold counter = HOLD_CYCLES-1, strobe = 1 next cycle, go to HOLD.
  - HOLD: strobe = 0 after its first cycle; the counter decrements each cycle.
    - At counter = 0, if FIFO non-empty: pop and load the next word back-to-back (strobe = 1 again, counter reloaded), stay in HOLD.
    - At counter = 0, if FIFO empty: go to IDLE, io_out_a unchanged.
  - Each word is on io_out_a for exactly HOLD_CYCLES cycles minimum.
  - HOLD_CYCLES = 1 gives one word per cycle.
- Latency: a word completed at edge N is in the FIFO after N. If the presenter is IDLE, io_out_a/strobe update at edge N+1. Minimum total is 2 edges from last byte sample to output.
- io_busy = (byte index != 0) || (io_count != 0) || (state == HOLD).
- Sustained throughput: 4 bytes per max(4, HOLD_CYCLES) cycles. When HOLD_CYCLES > 4 the FIFO fills and backpressure results.

Test Plan:
- Reset, then drive 4 bytes 11,22,33,44 back-to-back → one edge after the 4th byte, io_out_a=32'h44332211 and strobe=1 for 1 cycle. The value holds 4 cycles, then stays 32'h44332211 in IDLE; io_busy drops.
- Bytes AA,BB with io_in_last on BB → io_out_a=32'h0000BBAA; the next word starts at index 0.
- Stall: HOLD_CYCLES=8, DEPTH=4, continuous valid bytes → io_in_ready falls when io_count=4. No byte is lost or duplicated. Words appear in order, each held exactly 8 cycles, with strobe spaced 8 cycles apart.
- HOLD_CYCLES=1, FIFO preloaded with 3 words → 3 consecutive cycles of distinct words, strobe high each cycle, then IDLE with io_out_a holding the 3rd word.
- FIFO pointer wrap: push/pop 10 words with DEPTH=4 → output sequence matches input. io_count never exceeds 4.
- Assert reset mid-hold with 2 bytes of a partial word pending and 2 words queued → io_out_a=IDLE_WORD immediately (async). io_count=0, io_busy=0. After reset, the next 4 bytes form a clean word.
